mix_columns_iter: RTL and testbench

- Iterative, handshaked AES MixColumns / InvMixColumns engine. Successor to the fixed single-cycle forward-only mixer.
- Processes COLS_PER_CYCLE 32-bit columns per clock. The area/latency tradeoff is set by parameter.
- Supports forward, inverse and bypass modes per block. Sits between ShiftRows and AddRoundKey in the round datapath.

---
 rtl/mix_columns_iter.sv | 158 +++++++++++++++
 tb/tb_mix_columns_iter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns engine with a valid/ready block interface.
// COLS_PER_CYCLE columns are transformed per clock, so a block takes 4/COLS_PER_CYCLE compute cycles.
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [1:0]   in_mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int ITERS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_CNT = 2'(ITERS - 1);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [1:0]   cnt_q, cnt_d;
    logic [1:0]   mode_q, mode_d;
    logic [127:0] work_q, work_d;
    logic [127:0] out_q, out_d;
    logic         rdy;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a 4-bit constant as a chain of xtime terms.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic [1:0] mode);
        logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        case (mode)
            2'b00: begin
                b0 = gmul(a0, 4'd2) ^ gmul(a1, 4'd3) ^ a2 ^ a3;
                b1 = a0 ^ gmul(a1, 4'd2) ^ gmul(a2, 4'd3) ^ a3;
                b2 = a0 ^ a1 ^ gmul(a2, 4'd2) ^ gmul(a3, 4'd3);
                b3 = gmul(a0, 4'd3) ^ a1 ^ a2 ^ gmul(a3, 4'd2);
            end
            2'b01: begin
                b0 = gmul(a0, 4'he) ^ gmul(a1, 4'hb) ^ gmul(a2, 4'hd) ^ gmul(a3, 4'h9);
                b1 = gmul(a0, 4'h9) ^ gmul(a1, 4'he) ^ gmul(a2, 4'hb) ^ gmul(a3, 4'hd);
                b2 = gmul(a0, 4'hd) ^ gmul(a1, 4'h9) ^ gmul(a2, 4'he) ^ gmul(a3, 4'hb);
                b3 = gmul(a0, 4'hb) ^ gmul(a1, 4'hd) ^ gmul(a2, 4'h9) ^ gmul(a3, 4'he);
            end
            default: begin
                b0 = a0;
                b1 = a1;
                b2 = a2;
                b3 = a3;
            end
        endcase
        return {b0, b1, b2, b3};
    endfunction

    // Handshake: a block transfers on any edge where valid & ready are both high; a raised
    // out_valid and its out_state stay put until taken, and in_ready never depends on in_valid.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        out_d   = out_q;
        rdy     = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                rdy = 1'b1;
                if (in_valid) begin
                    work_d  = in_state;
                    mode_d  = in_mode;
                    cnt_d   = 2'd0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    work_d[((int'(cnt_q) * COLS_PER_CYCLE + k) & 3) * 32 +: 32] =
                        mix_col(work_q[((int'(cnt_q) * COLS_PER_CYCLE + k) & 3) * 32 +: 32], mode_q);
                end
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == LAST_CNT) begin
                    out_d   = work_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                rdy       = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        work_d  = in_state;
                        mode_d  = in_mode;
                        cnt_d   = 2'd0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 2'd0;
            mode_q  <= 2'd0;
            work_q  <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            out_q   <= out_d;
        end
    end

    // The state register sits in IDLE during reset, so readiness is masked explicitly.
    assign in_ready  = rdy & rst_n;
    assign out_state = out_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mix_columns_iter.sv
// Bench for mix_columns_iter: one instance per legal COLS_PER_CYCLE, a GF(2^8) matrix reference
// model, per-instance expected queues filled at accept and drained by a single output monitor.
module tb_mix_columns_iter;

    localparam int NI = 3;
    localparam logic [127:0] KAT_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] KAT_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] BYP_IN  = 128'h00112233_44556677_8899aabb_ccddeeff;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         in_valid [NI];
    logic         in_ready [NI];
    logic [127:0] in_state [NI];
    logic [1:0]   in_mode [NI];
    logic         out_valid [NI];
    logic         out_ready [NI];
    logic [127:0] out_state [NI];
    logic         busy [NI];
    logic         dir_rdy [NI];
    logic         rnd_bit [NI];
    logic         rnd_on = 1'b0;
    logic         fin = 1'b0;
    logic         model_done = 1'b0;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    logic [127:0] exp_q [NI][$];
    int           acc_q [NI][$];
    bit           seen [NI];

    generate
        for (genvar g = 0; g < NI; g++) begin : g_dut
            assign out_ready[g] = rnd_on ? rnd_bit[g] : dir_rdy[g];
            mix_columns_iter #(.COLS_PER_CYCLE(1 << g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[g]),
                .in_ready  (in_ready[g]),
                .in_state  (in_state[g]),
                .in_mode   (in_mode[g]),
                .out_valid (out_valid[g]),
                .out_ready (out_ready[g]),
                .out_state (out_state[g]),
                .busy      (busy[g])
            );
        end
    endgenerate

    // ---------------- clock/reset helpers ----------------
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) rnd_bit[i] <= ($urandom_range(0, 3) != 0);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gf_mul8(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] mode);
        logic [7:0]   row [4];
        logic [7:0]   a [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (mode[1]) return s;
        if (mode == 2'b00) begin
            row[0] = 8'h02; row[1] = 8'h03; row[2] = 8'h01; row[3] = 8'h01;
        end else begin
            row[0] = 8'h0e; row[1] = 8'h0b; row[2] = 8'h0d; row[3] = 8'h09;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[c*32 + 24 - 8*j +: 8];
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul8(row[(j - r) & 3], a[j]);
                res[c*32 + 24 - 8*r +: 8] = acc;
            end
        end
        return res;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    task automatic chk(input string name, input int inst, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d: got %h, expected %h", name, inst, cyc, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                exp_q[i].delete();
                acc_q[i].delete();
                seen[i] = 1'b0;
                chk("reset_out_valid", i, 128'(out_valid[i]), 128'd0);
                chk("reset_out_state", i, out_state[i], 128'd0);
                chk("reset_busy", i, 128'(busy[i]), 128'd0);
                chk("reset_in_ready", i, 128'(in_ready[i]), 128'd0);
            end
        end else begin
            if (!model_done) begin
                logic [127:0] x;
                chk("model_kat_fwd", 0, ref_mix(KAT_IN, 2'b00), KAT_OUT);
                chk("model_kat_inv", 0, ref_mix(KAT_OUT, 2'b01), KAT_IN);
                for (int n = 0; n < 8; n++) begin
                    x = {$urandom(), $urandom(), $urandom(), $urandom()};
                    chk("model_roundtrip", 0, ref_mix(ref_mix(x, 2'b00), 2'b01), x);
                end
                model_done = 1'b1;
            end
            for (int i = 0; i < NI; i++) begin
                chk("busy", i, 128'(busy[i]), 128'(exp_q[i].size() != 0));
                if (exp_q[i].size() == 0) begin
                    chk("idle_in_ready", i, 128'(in_ready[i]), 128'd1);
                    chk("no_stale_out_valid", i, 128'(out_valid[i]), 128'd0);
                end else if (out_valid[i]) begin
                    if (!seen[i]) begin
                        chk("latency", i, 128'(cyc - acc_q[i][0]), 128'((4 >> i) + 1));
                        seen[i] = 1'b1;
                    end
                    chk("out_state", i, out_state[i], exp_q[i][0]);
                    if (out_ready[i]) begin
                        void'(exp_q[i].pop_front());
                        void'(acc_q[i].pop_front());
                        seen[i] = 1'b0;
                    end else begin
                        chk("stall_in_ready", i, 128'(in_ready[i]), 128'd0);
                    end
                end else begin
                    chk("compute_in_ready", i, 128'(in_ready[i]), 128'd0);
                end
                if (in_valid[i] && in_ready[i]) begin
                    exp_q[i].push_back(ref_mix(in_state[i], in_mode[i]));
                    acc_q[i].push_back(cyc);
                end
                if (fin) chk("drained", i, 128'(exp_q[i].size()), 128'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input int i, input logic [127:0] s, input logic [1:0] m);
        int waited = 0;
        in_state[i] = s;
        in_mode[i]  = m;
        in_valid[i] = 1'b1;
        @(negedge clk);
        while (!in_ready[i]) begin
            waited++;
            if (waited > 200) begin
                $display("FAIL accept_timeout inst%0d: no in_ready after %0d cycles, required accept", i, waited);
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        in_state[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_mode[i]  = 2'($urandom_range(0, 3));
    endtask

    task automatic backpressure(input int i);
        dir_rdy[i] = 1'b0;
        send(i, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
        fork
            send(i, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
            begin
                int w = 0;
                while (!out_valid[i]) begin
                    @(negedge clk);
                    w++;
                    if (w > 20) begin
                        $display("FAIL out_valid_timeout inst%0d: none after %0d cycles, required result", i, w);
                        $fatal(1);
                    end
                end
                repeat (10) @(posedge clk);
                #1 dir_rdy[i] = 1'b1;
            end
        join
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_block();
        dir_rdy[0] = 1'b1;
        send(0, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'b00);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic run_random(input int i, input int n);
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            send(i, {$urandom(), $urandom(), $urandom(), $urandom()}, 2'($urandom_range(0, 3)));
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        for (int i = 0; i < NI; i++) begin
            in_valid[i] = 1'b0;
            in_state[i] = '0;
            in_mode[i]  = 2'b00;
            dir_rdy[i]  = 1'b1;
        end
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        fork
            send(0, KAT_IN, 2'b00);
            send(1, KAT_OUT, 2'b01);
            send(2, BYP_IN, 2'b10);
        join
        repeat (8) @(posedge clk);
        #1;

        for (int i = 0; i < NI; i++) backpressure(i);

        reset_mid_block();

        rnd_on = 1'b1;
        fork
            run_random(0, 334);
            run_random(1, 333);
            run_random(2, 333);
        join
        repeat (2) @(posedge clk);
        #1 rnd_on = 1'b0;
        repeat (12) @(posedge clk);
        #1 fin = 1'b1;
        @(negedge clk);
        #1 fin = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
